lcd_bus_receiver: RTL
=====================

Name: lcd_bus_receiver

Overview:
- Synthesizable HD44780-style responder for the 8-bit parallel LCD bus: the receiving end of the LCD driver (signals RS, EN, DB[7:0]).
- Latches a transaction on each EN falling edge, checks the EN pulse width and busy-time violations, and decodes the command set.
- Maintains a 2x16 DDRAM, the cursor and the display flags, with a read-back port.
- Used as an on-chip loopback target and as a bench checker for the sensor display path.

Parameters:
MIN_EN_CYCLES, 23, minimum EN-high clocks for a valid latch (450 ns at 50 MHz)
BUSY_CYCLES, 2000, busy duration for normal commands and data writes (40 us)
CLEAR_BUSY_CYCLES, 82000, busy duration for clear/home (1.64 ms); must be >= 32

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
lcd_rs  in  1  register select (0 = command, 1 = data); same clock domain, no synchronizer
lcd_en  in  1  enable strobe
lcd_data_bus  in  8  data/command byte
rd_addr  in  5  DDRAM read index {line, col[3:0]}
rd_data  out  8  DDRAM read data; 1-cycle latency
err_clr  in  1  clears the sticky error flags
busy  out  1  busy flag
cursor_addr  out  7  DDRAM address counter (0x00-0x0F, 0x40-0x4F)
display_on, cursor_on, blink_on  out  1 each  display-control flags
entry_inc, entry_shift  out  1 each  entry-mode flags
cmd_strobe, data_strobe  out  1 each  1-cycle pulse per accepted transaction
rx_byte  out  8  last accepted byte
timing_err, busy_err, addr_err  out  1 each  sticky violation flags

Behaviour:
- Reset values:
  - busy=1, cursor_addr=0, display_on/cursor_on/blink_on=0, entry_inc=1, entry_shift=0.
  - Strobes=0, rx_byte=0, all error flags=0, rd_data=0x00.
  - State=CLEAR with wipe index 0.
- Reset wipe: after reset release, 32 cycles write 0x20 to every DDRAM entry, then busy=0 and state goes to IDLE. The reset wipe does not add a CLEAR_BUSY_CYCLES window.
- Reset mid-operation: aborts everything and restarts the wipe.
- EN sampling:
  - Register en_q, rs_q and data_q every cycle.
  - hi_cnt counts consecutive EN-high cycles, saturating at MIN_EN_CYCLES.
  - Falling edge = en_q & ~lcd_en. The transaction uses rs_q/data_q, i.e. values from the last EN-high cycle.
  - RS/DB changes while EN is high are legal; the last value wins.
- Acceptance at the falling-edge clock:
  - hi_cnt < MIN_EN_CYCLES: set timing_err, discard.
  - Else, busy=1: set busy_err, discard.
  - Else accept. On the same edge: rx_byte, one strobe, DDRAM/flag update, busy=1, busy counter loaded.
- Command decode (highest set bit wins):
  - 0x01 clear: wipe to 0x20 (32 cycles, state CLEAR), cursor=0, entry_inc=1; busy for CLEAR_BUSY_CYCLES.
  - 0x02/0x03 home: cursor=0; busy for CLEAR_BUSY_CYCLES.
  - 0x04-0x07 entry mode: entry_inc=b1, entry_shift=b0.
  - 0x08-0x0F display control: display_on=b2, cursor_on=b1, blink_on=b0.
  - 0x10-0x1F shift:
    - b3=0: cursor moves (b2=1 increment, else decrement) with the wrap rule below.
    - b3=1: display shift, accepted with no effect.
  - 0x20-0x7F function set/CGRAM address: accepted, no state change.
  - 0x80+a set DDRAM address: if a[5:4]==0, cursor=a[6:0]; else set addr_err, cursor unchanged. The command is still accepted (strobe and busy).
  - 0x00: no-op; cmd_strobe fires, busy not asserted.
  - Non-clear commands and data use BUSY_CYCLES.
- Data write:
  - DDRAM[{cursor[6],cursor[3:0]}] = byte.
  - Cursor then moves by entry_inc.
- Cursor wrap:
  - Increment: 0x0F→0x40, 0x4F→0x00.
  - Decrement: 0x00→0x4F, 0x40→0x0F.
- Busy: a down-counter (17 bits) runs in state EXEC and returns to IDLE when it hits 0. CLEAR finishes its wipe, then continues counting down.
- Read port: rd_data = DDRAM[rd_addr], registered. A read and a write to the same index in the same cycle returns the old data.
- Error flags:
  - err_clr clears the flags.
  - A set and err_clr in the same cycle: set wins.

Decomposition:
- lcd_pkg holds:
  - Command opcodes/masks (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, SET_DDRAM).
  - State enum (CLEAR, IDLE, EXEC).
  - LINE2_BASE=0x40, DDRAM_DEPTH=32, BLANK_CHAR=0x20.
- Sub-module lcd_ddram: 32x8 RAM with one write port and one registered read port; the wipe is driven by the parent.

Test Plan:
- Reset, wait 32 cycles -> busy falls; rd_addr 0..31 all read 0x20; cursor_addr=0.
- Command 0x0F with a 25-cycle EN pulse -> cmd_strobe once, display/cursor/blink=1, busy high for 2000 cycles.
- Data 0x41 then 0x42 (each after busy clears) -> DDRAM[0]=0x41, DDRAM[1]=0x42, cursor_addr=0x02.
- Cursor wrap:
  - Set address 0x8F, write 0x33 -> DDRAM[15]=0x33, cursor=0x40.
  - Entry mode 0x04 then write at 0x40 -> cursor=0x0F.
- Error flags:
  - 10-cycle EN pulse -> timing_err=1, DDRAM unchanged.
  - Valid pulse during busy -> busy_err=1, ignored.
  - Set address 0xA0 -> addr_err=1, cursor unchanged.
  - err_clr -> all flags 0.
- Clear 0x01 after text -> all entries 0x20 within 32 cycles, busy held for 82000 cycles, cursor=0; rst asserted mid-wipe -> wipe restarts.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus receiver: opcodes, states and
// DDRAM address helpers.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_ENTRY     = 8'h04;
   localparam logic [7:0] CMD_DISPCTL   = 8'h08;
   localparam logic [7:0] CMD_SHIFT     = 8'h10;
   localparam logic [7:0] CMD_FUNC_MASK = 8'h60;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

   localparam logic [6:0] ADDR_BAD_MASK = 7'h30;
   localparam logic [6:0] LINE2_BASE    = 7'h40;
   localparam int unsigned DDRAM_DEPTH  = 32;
   localparam logic [7:0] BLANK_CHAR    = 8'h20;

   typedef enum logic [1:0] {StClear, StIdle, StExec} state_e;

   typedef enum logic [2:0] {
      CmdNop, CmdClear, CmdHome, CmdEntry, CmdDispCtl, CmdShift, CmdFunc, CmdSetDdram
   } cmd_e;

   // Highest set bit selects the instruction.
   function automatic cmd_e decode_cmd(input logic [7:0] b);
      cmd_e c;
      if ((b & CMD_SET_DDRAM) != 8'h00)      c = CmdSetDdram;
      else if ((b & CMD_FUNC_MASK) != 8'h00) c = CmdFunc;
      else if ((b & CMD_SHIFT) != 8'h00)     c = CmdShift;
      else if ((b & CMD_DISPCTL) != 8'h00)   c = CmdDispCtl;
      else if ((b & CMD_ENTRY) != 8'h00)     c = CmdEntry;
      else if ((b & CMD_HOME) != 8'h00)      c = CmdHome;
      else if ((b & CMD_CLEAR) != 8'h00)     c = CmdClear;
      else                                   c = CmdNop;
      return c;
   endfunction

   // Cursor step with line wrap: 0x0F <-> 0x40 and 0x4F <-> 0x00.
   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
      logic [6:0] n;
      if (inc) begin
         if (a[3:0] == 4'hF) n = a[6] ? 7'h00 : LINE2_BASE;
         else                n = a + 7'd1;
      end else begin
         if (a[3:0] == 4'h0) n = a[6] ? 7'h0F : (LINE2_BASE | 7'h0F);
         else                n = a - 7'd1;
      end
      return n;
   endfunction

   function automatic logic [4:0] ddram_index(input logic [6:0] a);
      return {a[6], a[3:0]};
   endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 2x16 character DDRAM: one write port, one registered read port.
// Reads of an index being written in the same cycle return the old byte.
module lcd_ddram
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem_q [DDRAM_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= 8'h00;
      end else begin
         rd_data <= mem_q[rd_addr];
      end
   end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiving end of an 8-bit HD44780 parallel bus: latches on EN fall, checks timing and
// busy violations, decodes commands and keeps DDRAM, cursor and display flags.
module lcd_bus_receiver
   import lcd_pkg::*;
#(
   parameter int unsigned MIN_EN_CYCLES     = 23,
   parameter int unsigned BUSY_CYCLES       = 2000,
   parameter int unsigned CLEAR_BUSY_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_rs,
   input  logic       lcd_en,
   input  logic [7:0] lcd_data_bus,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic       err_clr,
   output logic       busy,
   output logic [6:0] cursor_addr,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic       entry_shift,
   output logic       cmd_strobe,
   output logic       data_strobe,
   output logic [7:0] rx_byte,
   output logic       timing_err,
   output logic       busy_err,
   output logic       addr_err
);

   localparam int unsigned   HiW       = $clog2(MIN_EN_CYCLES + 1);
   localparam logic [HiW-1:0] HiMax    = HiW'(MIN_EN_CYCLES);
   localparam logic [16:0]   BusyLoad  = 17'(BUSY_CYCLES - 1);
   localparam logic [16:0]   ClearLoad = 17'(CLEAR_BUSY_CYCLES - 1);
   localparam logic [4:0]    WipeLast  = 5'(DDRAM_DEPTH - 1);

   state_e         state_q;
   logic [4:0]     wipe_idx_q;
   logic [16:0]    busy_cnt_q;
   logic           en_q, rs_q;
   logic [7:0]     data_q;
   logic [HiW-1:0] hi_cnt_q;
   logic           busy_q;
   logic [6:0]     cursor_q;
   logic           display_on_q, cursor_on_q, blink_on_q, entry_inc_q, entry_shift_q;
   logic           cmd_strobe_q, data_strobe_q;
   logic [7:0]     rx_byte_q;
   logic           timing_err_q, busy_err_q, addr_err_q;

   logic           fall, wide_enough, accept;
   cmd_e           cmd;
   logic           ram_we;
   logic [4:0]     ram_waddr;
   logic [7:0]     ram_wdata;

   assign fall        = en_q & ~lcd_en;
   assign wide_enough = (hi_cnt_q == HiMax);
   assign accept      = fall & wide_enough & ~busy_q;
   assign cmd         = decode_cmd(data_q);

   // Wipe owns the write port while clearing; accepts only happen when idle.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = ddram_index(cursor_q);
      ram_wdata = data_q;
      if (!rst) begin
         if (state_q == StClear) begin
            ram_we    = 1'b1;
            ram_waddr = wipe_idx_q;
            ram_wdata = BLANK_CHAR;
         end else if (accept && rs_q) begin
            ram_we = 1'b1;
         end
      end
   end

   lcd_ddram u_ddram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StClear;
         wipe_idx_q    <= '0;
         busy_cnt_q    <= '0;
         en_q          <= 1'b0;
         rs_q          <= 1'b0;
         data_q        <= 8'h00;
         hi_cnt_q      <= '0;
         busy_q        <= 1'b1;
         cursor_q      <= '0;
         display_on_q  <= 1'b0;
         cursor_on_q   <= 1'b0;
         blink_on_q    <= 1'b0;
         entry_inc_q   <= 1'b1;
         entry_shift_q <= 1'b0;
         cmd_strobe_q  <= 1'b0;
         data_strobe_q <= 1'b0;
         rx_byte_q     <= 8'h00;
         timing_err_q  <= 1'b0;
         busy_err_q    <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         en_q          <= lcd_en;
         rs_q          <= lcd_rs;
         data_q        <= lcd_data_bus;
         hi_cnt_q      <= !lcd_en ? '0 : (wide_enough ? hi_cnt_q : hi_cnt_q + 1'b1);
         cmd_strobe_q  <= 1'b0;
         data_strobe_q <= 1'b0;

         if (err_clr) begin
            timing_err_q <= 1'b0;
            busy_err_q   <= 1'b0;
            addr_err_q   <= 1'b0;
         end

         unique case (state_q)
            StClear: begin
               wipe_idx_q <= wipe_idx_q + 5'd1;
               // Busy keeps counting during the wipe; a reset wipe starts from zero.
               if (wipe_idx_q == WipeLast) begin
                  if (busy_cnt_q == '0) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q    <= StExec;
                     busy_cnt_q <= busy_cnt_q - 17'd1;
                  end
               end else if (busy_cnt_q != '0) begin
                  busy_cnt_q <= busy_cnt_q - 17'd1;
               end
            end
            StExec: begin
               if (busy_cnt_q == '0) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  busy_cnt_q <= busy_cnt_q - 17'd1;
               end
            end
            default: ;
         endcase

         if (fall) begin
            if (!wide_enough) begin
               timing_err_q <= 1'b1;
            end else if (busy_q) begin
               busy_err_q <= 1'b1;
            end else begin
               rx_byte_q <= data_q;
               if (rs_q) begin
                  data_strobe_q <= 1'b1;
                  cursor_q      <= step_addr(cursor_q, entry_inc_q);
                  busy_q        <= 1'b1;
                  busy_cnt_q    <= BusyLoad;
                  state_q       <= StExec;
               end else begin
                  cmd_strobe_q <= 1'b1;
                  if (cmd != CmdNop) begin
                     busy_q     <= 1'b1;
                     busy_cnt_q <= BusyLoad;
                     state_q    <= StExec;
                  end
                  unique case (cmd)
                     CmdClear: begin
                        state_q     <= StClear;
                        wipe_idx_q  <= '0;
                        cursor_q    <= '0;
                        entry_inc_q <= 1'b1;
                        busy_cnt_q  <= ClearLoad;
                     end
                     CmdHome: begin
                        cursor_q   <= '0;
                        busy_cnt_q <= ClearLoad;
                     end
                     CmdEntry: begin
                        entry_inc_q   <= data_q[1];
                        entry_shift_q <= data_q[0];
                     end
                     CmdDispCtl: begin
                        display_on_q <= data_q[2];
                        cursor_on_q  <= data_q[1];
                        blink_on_q   <= data_q[0];
                     end
                     CmdShift: begin
                        if (!data_q[3]) cursor_q <= step_addr(cursor_q, data_q[2]);
                     end
                     CmdSetDdram: begin
                        if ((data_q[6:0] & ADDR_BAD_MASK) != 7'h00) addr_err_q <= 1'b1;
                        else                                        cursor_q   <= data_q[6:0];
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   assign busy        = busy_q;
   assign cursor_addr = cursor_q;
   assign display_on  = display_on_q;
   assign cursor_on   = cursor_on_q;
   assign blink_on    = blink_on_q;
   assign entry_inc   = entry_inc_q;
   assign entry_shift = entry_shift_q;
   assign cmd_strobe  = cmd_strobe_q;
   assign data_strobe = data_strobe_q;
   assign rx_byte     = rx_byte_q;
   assign timing_err  = timing_err_q;
   assign busy_err    = busy_err_q;
   assign addr_err    = addr_err_q;

endmodule
